axis_peak_find: RTL and testbench

Burst peak detector that sits downstream of the zero-pad/interpolation chain in the peak path. It consumes a tlast-delimited burst of complex samples, computes each sample's power I²+Q², and tracks the maximum and its sample index. At end of burst it emits one result beat carrying peak power, peak index and an overflow flag. A 3-stage pipeline accepts one sample per clock with no inter-burst gap.

---
 rtl/axis_peak_find.sv | 190 +++++++++++++++++++
 tb/tb_axis_peak_find.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_peak_find.sv
`default_nettype none
// ============================================================================
// Module   : axis_peak_find
// Purpose  : Burst peak detector. Computes I^2+Q^2 per sample of a
//            tlast-delimited burst, tracks the maximum power and its index,
//            and emits one result beat (power, index, overflow) per burst.
// Revision : 1.0 - initial release
// ============================================================================
module axis_peak_find #(
  parameter  int MAX_LEN     = 4096,
  localparam int INDEX_WIDTH = $clog2(MAX_LEN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [31:0]            s_axis_tdata,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            m_axis_tdata,
  output logic [INDEX_WIDTH-1:0] m_axis_tindex,
  output logic                   m_axis_tovf
);

  localparam logic [INDEX_WIDTH-1:0] c_CNT_MAX = INDEX_WIDTH'(MAX_LEN - 1);

  logic                   w_en;
  logic                   w_accept;
  logic                   w_cnt_sat;
  logic                   w_beat_ovf;
  logic signed [30:0]     w_i_ext;
  logic signed [30:0]     w_q_ext;
  logic [30:0]            w_ii;
  logic [30:0]            w_qq;
  logic                   w_take;
  logic                   w_load;

  // Input-side burst bookkeeping
  logic [INDEX_WIDTH-1:0] r_cnt;
  logic                   r_ovf;

  // Stage 1: squares
  logic                   r_s1_valid;
  logic                   r_s1_last;
  logic                   r_s1_ovf;
  logic [INDEX_WIDTH-1:0] r_s1_idx;
  logic [30:0]            r_s1_ii;
  logic [30:0]            r_s1_qq;

  // Stage 2: power
  logic                   r_s2_valid;
  logic                   r_s2_last;
  logic                   r_s2_ovf;
  logic [INDEX_WIDTH-1:0] r_s2_idx;
  logic [31:0]            r_s2_pwr;

  // Stage 3: running maximum
  logic                   r_s3_valid;
  logic                   r_s3_last;
  logic                   r_s3_ovf;
  logic                   r_first;
  logic [31:0]            r_max;
  logic [INDEX_WIDTH-1:0] r_max_idx;

  // Result registers
  logic                   r_m_valid;
  logic [31:0]            r_m_data;
  logic [INDEX_WIDTH-1:0] r_m_idx;
  logic                   r_m_ovf;

  // Whole pipeline advances only when the result slot is free or being taken
  always_comb begin
    w_en       = !r_m_valid || m_axis_tready;
    w_accept   = s_axis_tvalid && w_en;
    w_cnt_sat  = (r_cnt == c_CNT_MAX);
    w_beat_ovf = r_ovf || w_cnt_sat;
    // Sign-extending to 31 bits keeps the square exact: max is 2^30
    w_i_ext    = {{15{s_axis_tdata[31]}}, s_axis_tdata[31:16]};
    w_q_ext    = {{15{s_axis_tdata[15]}}, s_axis_tdata[15:0]};
    w_ii       = w_i_ext * w_i_ext;
    w_qq       = w_q_ext * w_q_ext;
    // First sample of a burst loads unconditionally; ties keep the earliest
    w_take     = r_first || (r_s2_pwr > r_max);
    w_load     = r_s3_valid && r_s3_last;
  end

  assign s_axis_tready = w_en;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tindex = r_m_idx;
  assign m_axis_tovf   = r_m_ovf;

  // Sample index counter with saturation and sticky burst overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (s_axis_tlast) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_cnt_sat) begin
        r_ovf <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Stage 1: register squares and sideband of the accepted beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_ii    <= '0;
      r_s1_qq    <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_last <= s_axis_tlast;
        r_s1_ovf  <= w_beat_ovf;
        r_s1_idx  <= r_cnt;
        r_s1_ii   <= w_ii;
        r_s1_qq   <= w_qq;
      end
    end
  end

  // Stage 2: sum of squares, fits 32 bits without saturation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_pwr   <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_ovf   <= r_s1_ovf;
      r_s2_idx   <= r_s1_idx;
      r_s2_pwr   <= {1'b0, r_s1_ii} + {1'b0, r_s1_qq};
    end
  end

  // Stage 3: running max compare; a tlast sample re-arms the first-sample flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      r_s3_ovf   <= 1'b0;
      r_first    <= 1'b1;
      r_max      <= '0;
      r_max_idx  <= '0;
    end else if (w_en) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_last <= r_s2_last;
        r_s3_ovf  <= r_s2_ovf;
        r_first   <= r_s2_last;
        if (w_take) begin
          r_max     <= r_s2_pwr;
          r_max_idx <= r_s2_idx;
        end
      end
    end
  end

  // Result register: a new load wins over the handshake clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_idx   <= '0;
      r_m_ovf   <= 1'b0;
    end else if (w_en) begin
      r_m_valid <= w_load;
      if (w_load) begin
        r_m_data <= r_max;
        r_m_idx  <= r_max_idx;
        r_m_ovf  <= r_s3_ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_peak_find.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_peak_find
// Purpose  : Directed self-checking bench for axis_peak_find (MAX_LEN=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_peak_find;

  logic        clk;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tindex;
  logic        m_tovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] q_res[$];
  logic [31:0] vec[$];

  axis_peak_find #(.MAX_LEN(16)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tindex (m_tindex),
    .m_axis_tovf   (m_tovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every result handshake between edges
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) q_res.push_back({m_tdata, m_tindex, m_tovf});
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int i, input int q);
    logic [31:0] v;
    v = {i[15:0], q[15:0]};
    return v;
  endfunction

  // Drive one beat and hold it until the DUT accepts it
  task automatic send(input logic [31:0] d, input logic last);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_vec();
    for (int i = 0; i < vec.size(); i++) send(vec[i], i == vec.size() - 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] e_data,
                             input logic [3:0] e_idx, input logic e_ovf);
    int n;
    logic [36:0] r;
    n = 0;
    while (q_res.size() == 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q_res.size() == 0) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      r = q_res.pop_front();
      check_eq({tag, "_data"}, {32'd0, r[36:5]}, {32'd0, e_data});
      check_eq({tag, "_idx"},  {60'd0, r[4:1]},  {60'd0, e_idx});
      check_eq({tag, "_ovf"},  {63'd0, r[0]},    {63'd0, e_ovf});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tready_in_reset", {63'd0, s_tready}, 64'd1);
    rst_n = 1'b1;
    check_eq("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    check_eq("rst_tdata",  {32'd0, m_tdata},  64'd0);
    check_eq("rst_tindex", {60'd0, m_tindex}, 64'd0);
    check_eq("rst_tovf",   {63'd0, m_tovf},   64'd0);
    check_eq("rst_tready", {63'd0, s_tready}, 64'd1);

    // Basic peak with latency check
    vec.delete();
    for (int k = 0; k < 8; k++) vec.push_back(k == 5 ? pk(1000, -1000) : pk(k * 100, k * 100));
    send_vec();
    check_eq("lat_n0", {63'd0, m_tvalid}, 64'd0);
    @(posedge clk); #1;
    check_eq("lat_n1", {63'd0, m_tvalid}, 64'd0);
    @(posedge clk); #1;
    check_eq("lat_n2", {63'd0, m_tvalid}, 64'd0);
    @(posedge clk); #1;
    check_eq("lat_n3", {63'd0, m_tvalid}, 64'd1);
    wait_result("basic", 32'd2000000, 4'd5, 1'b0);

    // Ties keep earliest index
    vec.delete();
    vec.push_back(pk(3, 4));
    vec.push_back(pk(-5, 0));
    vec.push_back(pk(0, 5));
    send_vec();
    wait_result("tie", 32'd25, 4'd0, 1'b0);

    // Single-sample burst at the negative extreme
    vec.delete();
    vec.push_back(pk(-32768, -32768));
    send_vec();
    wait_result("single", 32'h8000_0000, 4'd0, 1'b0);

    // Backpressure across two back-to-back bursts
    m_tready = 1'b0;
    fork
      begin
        vec.delete();
        vec.push_back(pk(10, 0));
        vec.push_back(pk(0, 20));
        vec.push_back(pk(5, 5));
        for (int i = 0; i < 3; i++) send(vec[i], i == 2);
        vec.delete();
        vec.push_back(pk(1, 1));
        vec.push_back(pk(2, 2));
        vec.push_back(pk(-7, 1));
        vec.push_back(pk(3, 3));
        send_vec();
      end
      begin
        int n;
        n = 0;
        while (!m_tvalid && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        check_eq("bp_first_valid", {63'd0, m_tvalid}, 64'd1);
        for (int c = 0; c < 10; c++) begin
          check_eq("bp_tready_low", {63'd0, s_tready}, 64'd0);
          check_eq("bp_hold_data",  {32'd0, m_tdata},  64'd400);
          check_eq("bp_hold_idx",   {60'd0, m_tindex}, 64'd1);
          @(posedge clk); #1;
        end
        m_tready = 1'b1;
      end
    join
    wait_result("bp_a", 32'd400, 4'd1, 1'b0);
    wait_result("bp_b", 32'd50, 4'd2, 1'b0);

    // Overflow: 20 samples into MAX_LEN=16, peak at sample 18
    vec.delete();
    for (int k = 0; k < 20; k++) vec.push_back(k == 18 ? pk(100, 100) : pk(1, 0));
    send_vec();
    wait_result("ovf", 32'd20000, 4'd15, 1'b1);
    vec.delete();
    vec.push_back(pk(1, 1));
    vec.push_back(pk(2, 0));
    vec.push_back(pk(0, 3));
    vec.push_back(pk(1, 0));
    send_vec();
    wait_result("post_ovf", 32'd9, 4'd2, 1'b0);

    // Reset mid-burst discards the partial burst
    repeat (5) @(posedge clk);
    #1;
    q_res.delete();
    for (int k = 0; k < 3; k++) send(pk(1000, 1000), 1'b0);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vec.delete();
    vec.push_back(pk(1, 0));
    vec.push_back(pk(2, 0));
    send_vec();
    wait_result("rst_mid", 32'd4, 4'd1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("rst_mid_extra", {32'd0, 32'(q_res.size())}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
